// File: rtl/ks_pkg.sv
// Shared Kogge-Stone helpers: bit-level propagate/generate and the prefix black cell.
// Intended for reuse by the combinational adder and the pipelined subtractor.
package ks_pkg;

  localparam int KS_MAX_WIDTH = 64;

  // Subtract form: operand b is inverted, so G = a & ~b, P = a ^ ~b. Returns {G,P}.
  function automatic logic [1:0] pg_init(input logic a, input logic b);
    return {a & ~b, a ^ ~b};
  endfunction

  function automatic logic [1:0] pg_black(input logic g_hi, input logic p_hi,
                                          input logic g_lo, input logic p_lo);
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

endpackage

// File: rtl/ks_prefix_stage.sv
// One registered Kogge-Stone prefix level; sideband bits (P0, carry-in, signs) ride along.
// Every register holds when en is low, so the whole pipe stalls as one.
module ks_prefix_stage
  import ks_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SPAN   = 1,
  parameter int SIDE_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              valid_in,
  input  logic [WIDTH-1:0]  g_in,
  input  logic [WIDTH-1:0]  p_in,
  input  logic [SIDE_W-1:0] side_in,
  output logic              valid_out,
  output logic [WIDTH-1:0]  g_out,
  output logic [WIDTH-1:0]  p_out,
  output logic [SIDE_W-1:0] side_out
);

  logic [WIDTH-1:0]  g_d, p_d;
  logic [WIDTH-1:0]  g_q, p_q;
  logic [SIDE_W-1:0] side_q;
  logic              valid_q;

  // Bits below SPAN have no partner this level and pass straight through.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= SPAN) begin : g_black
      assign {g_d[i], p_d[i]} = pg_black(g_in[i], p_in[i], g_in[i-SPAN], p_in[i-SPAN]);
    end else begin : g_pass
      assign {g_d[i], p_d[i]} = {g_in[i], p_in[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      g_q     <= '0;
      p_q     <= '0;
      side_q  <= '0;
    end else if (en) begin
      valid_q <= valid_in;
      g_q     <= g_d;
      p_q     <= p_d;
      side_q  <= side_in;
    end
  end

  assign valid_out = valid_q;
  assign g_out     = g_q;
  assign p_out     = p_q;
  assign side_out  = side_q;

endmodule

// File: rtl/ks_sub_pipe_16bit.sv
// Pipelined Kogge-Stone subtractor Y = A - B - BIN: PG input stage, one register per
// prefix level, final level + sum registered at the output. Whole-pipe stall on backpressure.
module ks_sub_pipe_16bit
  import ks_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             BOUT,
  output logic             OVF
);

  localparam int LEVELS     = $clog2(WIDTH);
  localparam int SIDE_W     = WIDTH + 3;
  localparam int FINAL_SPAN = 1 << (LEVELS - 1);

  logic adv;

  logic [WIDTH-1:0]  s0_g_d, s0_p_d;
  logic [SIDE_W-1:0] s0_side_d;
  logic              s0_valid_q;
  logic [WIDTH-1:0]  s0_g_q, s0_p_q;
  logic [SIDE_W-1:0] s0_side_q;

  logic [LEVELS-1:0]             valid_s;
  logic [LEVELS-1:0][WIDTH-1:0]  g_s, p_s;
  logic [LEVELS-1:0][SIDE_W-1:0] side_s;

  logic [WIDTH-1:0] gf_d, pf_d, p0_f, carry_d, y_d;
  logic             cin_f, a_msb_f, b_msb_f, bout_d, ovf_d;

  logic             out_valid_q, bout_q, ovf_q;
  logic [WIDTH-1:0] y_q;

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  // Sideband layout: {B msb, A msb, carry-in (~BIN), P0}.
  always_comb begin
    s0_g_d = '0;
    s0_p_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {s0_g_d[i], s0_p_d[i]} = pg_init(A[i], B[i]);
    end
    s0_side_d = {B[WIDTH-1], A[WIDTH-1], ~BIN, s0_p_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_g_q     <= '0;
      s0_p_q     <= '0;
      s0_side_q  <= '0;
    end else if (adv) begin
      s0_valid_q <= in_valid;
      s0_g_q     <= s0_g_d;
      s0_p_q     <= s0_p_d;
      s0_side_q  <= s0_side_d;
    end
  end

  assign valid_s[0] = s0_valid_q;
  assign g_s[0]     = s0_g_q;
  assign p_s[0]     = s0_p_q;
  assign side_s[0]  = s0_side_q;

  for (genvar k = 1; k < LEVELS; k++) begin : g_level
    ks_prefix_stage #(
      .WIDTH  (WIDTH),
      .SPAN   (1 << (k - 1)),
      .SIDE_W (SIDE_W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (adv),
      .valid_in  (valid_s[k-1]),
      .g_in      (g_s[k-1]),
      .p_in      (p_s[k-1]),
      .side_in   (side_s[k-1]),
      .valid_out (valid_s[k]),
      .g_out     (g_s[k]),
      .p_out     (p_s[k]),
      .side_out  (side_s[k])
    );
  end

  // Last prefix level is folded into the output stage together with the sum.
  for (genvar i = 0; i < WIDTH; i++) begin : g_final
    if (i >= FINAL_SPAN) begin : g_black
      assign {gf_d[i], pf_d[i]} = pg_black(g_s[LEVELS-1][i], p_s[LEVELS-1][i],
                                           g_s[LEVELS-1][i-FINAL_SPAN],
                                           p_s[LEVELS-1][i-FINAL_SPAN]);
    end else begin : g_pass
      assign {gf_d[i], pf_d[i]} = {g_s[LEVELS-1][i], p_s[LEVELS-1][i]};
    end
  end

  assign p0_f    = side_s[LEVELS-1][WIDTH-1:0];
  assign cin_f   = side_s[LEVELS-1][WIDTH];
  assign a_msb_f = side_s[LEVELS-1][WIDTH+1];
  assign b_msb_f = side_s[LEVELS-1][WIDTH+2];

  always_comb begin
    carry_d = {gf_d[WIDTH-2:0] | (pf_d[WIDTH-2:0] & {(WIDTH-1){cin_f}}), cin_f};
    y_d     = p0_f ^ carry_d;
    bout_d  = ~(gf_d[WIDTH-1] | (pf_d[WIDTH-1] & cin_f));
    ovf_d   = (a_msb_f ^ b_msb_f) & (y_d[WIDTH-1] ^ a_msb_f);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= valid_s[LEVELS-1];
      y_q         <= y_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Y         = y_q;
  assign BOUT      = bout_q;
  assign OVF       = ovf_q;

endmodule
